// File: rtl/uart_rx.sv
// Purpose : oversampling UART receiver (start, data_wd bits LSB first, optional parity, one stop).
// Latency : rx_done rises 2 clk after the stop-bit centre tick; 2 extra clk of input sync at frame start.
// Backpr. : none; rx_done is a 1-cycle strobe and the outputs hold until the next frame completes.
//
// Ports
//   clk, rst    : system clock (rising edge), asynchronous active-high reset
//   tick        : 1-cycle pulse at oversampling_rate x BAUD from the shared baud generator
//   rx          : asynchronous serial line, idles high
//   dout        : last received data word (updated even when the frame had errors)
//   rx_done     : 1-cycle strobe marking an update of dout / parity_err / frame_err
//   rx_busy     : high while a frame is being received
//   parity_err  : parity mismatch in the last frame (always 0 without a parity bit)
//   frame_err   : stop bit of the last frame sampled low
module uart_rx #(
    parameter int BAUD              = 9600,
    parameter int clk_freq          = 50_000_000,
    parameter int clk_period        = 1_000_000_000 / clk_freq,
    parameter int oversampling_rate = 16,
    parameter int data_wd           = 8,
    parameter int parity            = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               rx,
    output logic [data_wd-1:0] dout,
    output logic               rx_done,
    output logic               rx_busy,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int CNT_W = (oversampling_rate > 1) ? $clog2(oversampling_rate) : 1;
    localparam int IDX_W = (data_wd > 1) ? $clog2(data_wd) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(oversampling_rate / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(oversampling_rate - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(data_wd - 1);
    localparam bit               PAR_EN   = (parity == 1) || (parity == 2);

    // Present in the elaborated hierarchy only when the tick rate cannot be
    // produced from the system clock, which makes a bad configuration easy to spot.
    if ((BAUD * oversampling_rate > clk_freq) || (clk_period <= 0)) begin : g_tick_rate_unreachable
    end

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_START  = 6'b000010,
        S_DATA   = 6'b000100,
        S_PARITY = 6'b001000,
        S_STOP   = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [data_wd-1:0] shift_q, shift_d;
    logic               p_bit_q, p_bit_d;
    logic               stop_bit_q, stop_bit_d;
    logic [data_wd-1:0] dout_q, dout_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               rx_done_q, rx_done_d;
    logic               exp_par;
    logic               bit_centre;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign exp_par    = (parity == 1) ? ~^shift_q : ^shift_q;
    assign bit_centre = tick && (tick_cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick ? ((tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + CNT_W'(1)) : tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        p_bit_d      = p_bit_q;
        stop_bit_d   = stop_bit_q;
        dout_d       = dout_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Half a bit in: a line back high means a glitch, not a start bit.
                if (tick && (tick_cnt_q == CNT_MID)) begin
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_centre) begin
                    // Shift in at the MSB so the first (LSB) bit ends up at bit 0.
                    shift_d   = data_wd'({rx_s_q, shift_q} >> 1);
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_centre) begin
                    p_bit_d = rx_s_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // No wait for the end of the stop bit, so a following start edge is not missed.
                if (bit_centre) begin
                    stop_bit_d = rx_s_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                dout_d       = shift_q;
                parity_err_d = PAR_EN ? (p_bit_q != exp_par) : 1'b0;
                frame_err_d  = ~stop_bit_q;
                rx_done_d    = 1'b1;
                bit_idx_d    = '0;
                tick_cnt_d   = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state starts timing from zero; START leaves re-anchored on the bit centre.
        if (state_d != state_q) tick_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            p_bit_q      <= 1'b0;
            stop_bit_q   <= 1'b0;
            dout_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            p_bit_q      <= p_bit_d;
            stop_bit_q   <= stop_bit_d;
            dout_q       <= dout_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_done_q    <= rx_done_d;
        end
    end

    assign dout       = dout_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : directed bench for uart_rx with odd, no and even parity instances on separate lines.
// Latency : frames are checked after the transmitter model finishes the stop bit.
// Backpr. : none; every wait is a fixed number of clocks.
module tb_uart_rx;

    localparam int OSR    = 16;
    localparam int TDIV   = 4;
    localparam int BITCLK = OSR * TDIV;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } res_t;

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stopv;
        int         gap;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    int         tdiv = 0;
    logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic [7:0] dout_a [3];
    logic       done_a [3];
    logic       busy_a [3];
    logic       pe_a   [3];
    logic       fe_a   [3];

    res_t q0[$], q1[$], q2[$];
    int   wide_cnt [3];
    logic prev_done [3];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
        tick <= (tdiv == TDIV - 1);
    end

    uart_rx #(.oversampling_rate(OSR), .data_wd(8), .parity(1)) u_odd (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx0), .dout(dout_a[0]), .rx_done(done_a[0]),
        .rx_busy(busy_a[0]), .parity_err(pe_a[0]), .frame_err(fe_a[0]));
    uart_rx #(.oversampling_rate(OSR), .data_wd(8), .parity(0)) u_none (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx1), .dout(dout_a[1]), .rx_done(done_a[1]),
        .rx_busy(busy_a[1]), .parity_err(pe_a[1]), .frame_err(fe_a[1]));
    uart_rx #(.oversampling_rate(OSR), .data_wd(8), .parity(2)) u_even (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx2), .dout(dout_a[2]), .rx_done(done_a[2]),
        .rx_busy(busy_a[2]), .parity_err(pe_a[2]), .frame_err(fe_a[2]));

    initial begin
        for (int i = 0; i < 3; i++) begin
            wide_cnt[i]  = 0;
            prev_done[i] = 1'b0;
        end
    end

    // Capture every strobe and count strobes that last longer than one cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_a[i]) begin
                if (prev_done[i]) wide_cnt[i]++;
                case (i)
                    0:       q0.push_back({dout_a[i], pe_a[i], fe_a[i]});
                    1:       q1.push_back({dout_a[i], pe_a[i], fe_a[i]});
                    default: q2.push_back({dout_a[i], pe_a[i], fe_a[i]});
                endcase
            end
            prev_done[i] = done_a[i];
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(int ln, logic v);
        case (ln)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    function automatic int qsize(int ln);
        case (ln)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic res_t qpop(int ln);
        case (ln)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Serial transmitter model. pm: 1=odd, 2=even, else no parity bit.
    // A low stop bit is shortened to 3/4 bit so the following high line
    // deterministically turns the tail of the break into a false start.
    // cut>0 abandons the frame after that many clocks, leaving the line as is.
    task automatic send(int ln, int pm, logic [7:0] data, logic pflip, logic stopv, int cut);
        logic [11:0] bits;
        int          n;
        int          clks;
        int          len;
        bits = '0;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = data[i]; n++;
        end
        if (pm == 1 || pm == 2) begin
            bits[n] = ((pm == 1) ? ~^data : ^data) ^ pflip; n++;
        end
        bits[n] = stopv; n++;
        clks = 0;
        for (int b = 0; b < n; b++) begin
            drive(ln, bits[b]);
            len = (b == n - 1 && !stopv) ? (BITCLK * 3) / 4 : BITCLK;
            for (int c = 0; c < len; c++) begin
                if (cut != 0 && clks == cut) return;
                @(negedge clk);
                clks++;
            end
        end
        drive(ln, 1'b1);
    endtask

    task automatic expect_frame(int ln, string nm, logic [7:0] d, logic pe, logic fe);
        int   sz;
        res_t r;
        sz = qsize(ln);
        chk({nm, " strobes"}, sz, 1);
        if (sz > 0) begin
            r = qpop(ln);
            chk({nm, " dout"}, r.d, d);
            chk({nm, " parity_err"}, r.pe, pe);
            chk({nm, " frame_err"}, r.fe, fe);
        end
        while (qsize(ln) > 0) void'(qpop(ln));
    endtask

    vec_t       vt [7];
    logic [7:0] lb [3];

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b1, 2 * BITCLK, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'h3C, 1'b1, 1'b1, 2 * BITCLK, 8'h3C, 1'b1, 1'b0};
        vt[2] = '{8'h81, 1'b0, 1'b0, 2 * BITCLK, 8'h81, 1'b0, 1'b1};
        vt[3] = '{8'h55, 1'b0, 1'b1, 2 * BITCLK, 8'h55, 1'b0, 1'b0};
        vt[4] = '{8'h00, 1'b0, 1'b1, 0,          8'h00, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 1'b0, 1'b1, 0,          8'hFF, 1'b0, 1'b0};
        vt[6] = '{8'h5A, 1'b0, 1'b1, 2 * BITCLK, 8'h5A, 1'b0, 1'b0};
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h5A;

        rst = 1'b1;
        idle(3);
        chk("reset dout", dout_a[0], 8'h00);
        chk("reset rx_done", done_a[0], 1'b0);
        chk("reset rx_busy", busy_a[0], 1'b0);
        chk("reset parity_err", pe_a[0], 1'b0);
        chk("reset frame_err", fe_a[0], 1'b0);
        rst = 1'b0;
        idle(2 * BITCLK);

        // Odd-parity receiver: good, bad parity, break, recovery, back-to-back bytes.
        for (int v = 0; v < 7; v++) begin
            send(0, 1, vt[v].data, vt[v].pflip, vt[v].stopv, 0);
            idle(vt[v].gap);
            expect_frame(0, $sformatf("odd vec%0d", v), vt[v].exp_d, vt[v].exp_pe, vt[v].exp_fe);
            chk($sformatf("odd vec%0d busy after", v), busy_a[0], 1'b0);
        end

        // Glitch of 4 ticks: busy briefly, then back to idle with no strobe.
        drive(0, 1'b0);
        idle(10);
        chk("glitch busy during", busy_a[0], 1'b1);
        idle(6);
        drive(0, 1'b1);
        idle(BITCLK + 16);
        chk("glitch busy after", busy_a[0], 1'b0);
        chk("glitch no strobe", qsize(0), 0);
        chk("glitch dout held", dout_a[0], 8'h5A);

        // Back-to-back loopback without parity and with even parity.
        for (int ln = 1; ln < 3; ln++) begin
            for (int k = 0; k < 3; k++) begin
                send(ln, (ln == 1) ? 0 : 2, lb[k], 1'b0, 1'b1, 0);
                expect_frame(ln, $sformatf("lb%0d byte%0d", ln, k), lb[k], 1'b0, 1'b0);
            end
            idle(2 * BITCLK);
        end

        // Reset in the middle of data bit 4 aborts the frame at once.
        send(0, 1, 8'hC3, 1'b0, 1'b1, 5 * BITCLK + BITCLK / 2);
        chk("midframe busy", busy_a[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("async reset dout", dout_a[0], 8'h00);
        chk("async reset busy", busy_a[0], 1'b0);
        chk("async reset rx_done", done_a[0], 1'b0);
        chk("async reset parity_err", pe_a[0], 1'b0);
        chk("async reset frame_err", fe_a[0], 1'b0);
        drive(0, 1'b1);
        idle(3);
        rst = 1'b0;
        idle(2 * BITCLK);
        chk("aborted frame no strobe", qsize(0), 0);
        send(0, 1, 8'hC3, 1'b0, 1'b1, 0);
        idle(BITCLK);
        expect_frame(0, "after reset", 8'hC3, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) chk($sformatf("strobe width dut%0d", i), wide_cnt[i], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
